// File: rtl/rs_input_conditioner_pkg.sv
// Package for rs_input_conditioner: default parameters, channel indices and
// the command struct/priority function used by the top level.
`include "rs_input_conditioner_defs.svh"

package rs_input_conditioner_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = `MINI_DEBOUNCE_CYCLES;
  localparam int DEF_SYNC_STAGES     = `MINI_SYNC_STAGES;

  // Channel slots in the packed per-channel vectors.
  localparam int NUM_CH = 2;
  localparam int CH_SET = 0;
  localparam int CH_RST = 1;

  typedef struct packed {
    logic s;
    logic r;
    logic conflict;
  } cmd_t;

  // Reset wins: a set rise is dropped (and flagged) whenever reset's
  // debounced level is high on the same edge.
  function automatic cmd_t cmd_next(input logic s_rise, input logic r_rise,
                                    input logic r_db_next);
    cmd_t c;
    c.r        = r_rise;
    c.s        = s_rise & ~r_db_next;
    c.conflict = s_rise &  r_db_next;
    return c;
  endfunction

endpackage

// File: rtl/rs_input_conditioner_debounce_channel.sv
// debounce_channel: one pushbutton channel.
//   raw -> SYNC_STAGES flop synchroniser -> counter debouncer -> db.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   raw     in   asynchronous raw button
//   db      out  debounced level (registered)
//   db_next out  value db takes at the next edge (for edge detection upstream)
module debounce_channel
  import rs_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db,
  output logic db_next
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CNT_W-1:0]       cnt, cnt_next;

  assign sync = sync_q[SYNC_STAGES-1];

  // Any cycle where sync agrees with db restarts the count, so only a run of
  // DEBOUNCE_CYCLES disagreeing samples moves db. The counter never passes
  // CNT_LAST: it is cleared on the same edge db flips.
  always_comb begin
    db_next  = db;
    cnt_next = '0;
    if (sync != db) begin
      if (cnt == CNT_LAST) db_next  = sync;
      else                 cnt_next = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt    <= '0;
      db     <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      cnt    <= cnt_next;
      db     <= db_next;
    end
  end

endmodule

// File: rtl/rs_input_conditioner_defs.svh
// Shared defaults for the MINI pushbutton input blocks.
// Guarded so several blocks (and their packages) can pull it in.
`ifndef RS_INPUT_CONDITIONER_DEFS_SVH
`define RS_INPUT_CONDITIONER_DEFS_SVH

`define MINI_DEBOUNCE_CYCLES 16
`define MINI_SYNC_STAGES     2

`endif

// File: rtl/rs_input_conditioner.sv
// rs_input_conditioner: turns two bouncy buttons into clean one-cycle
// set/reset commands for the RSLatch, never asserting S and R together.
// Ports:
//   CLK      in   system clock
//   RST      in   synchronous active-high reset
//   S_RAW    in   raw set button (async)
//   R_RAW    in   raw reset button (async)
//   S        out  one-cycle set command
//   R        out  one-cycle reset command
//   S_DB     out  debounced set level
//   R_DB     out  debounced reset level
//   CONFLICT out  one-cycle flag: set command suppressed by reset priority
module rs_input_conditioner
  import rs_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic CLK,
  input  logic RST,
  input  logic S_RAW,
  input  logic R_RAW,
  output logic S,
  output logic R,
  output logic S_DB,
  output logic R_DB,
  output logic CONFLICT
);

  logic [NUM_CH-1:0] raw_v, db_v, db_nx_v;
  logic              s_rise, r_rise;
  cmd_t              cmd;

  assign raw_v[CH_SET] = S_RAW;
  assign raw_v[CH_RST] = R_RAW;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_ch (
      .clk     (CLK),
      .rst     (RST),
      .raw     (raw_v[i]),
      .db      (db_v[i]),
      .db_next (db_nx_v[i])
    );
  end

  assign S_DB = db_v[CH_SET];
  assign R_DB = db_v[CH_RST];

  // Rises are taken from next-state values so the registered pulse lines up
  // with the first cycle the debounced level reads 1.
  assign s_rise = db_nx_v[CH_SET] & ~db_v[CH_SET];
  assign r_rise = db_nx_v[CH_RST] & ~db_v[CH_RST];
  assign cmd    = cmd_next(s_rise, r_rise, db_nx_v[CH_RST]);

  always_ff @(posedge CLK) begin
    if (RST) begin
      S        <= 1'b0;
      R        <= 1'b0;
      CONFLICT <= 1'b0;
    end else begin
      S        <= cmd.s;
      R        <= cmd.r;
      CONFLICT <= cmd.conflict;
    end
  end

endmodule
